// File: rtl/sap1_controller_pkg.sv
// sap1_controller_pkg: opcodes, control-word bit indices and sizes shared by the SAP-1 controller.
package sap1_controller_pkg;
    localparam int OP_W     = 4;
    localparam int T_STATES = 6;
    localparam int CON_W    = 12;
    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;
    localparam int CON_CP = 11;
    localparam int CON_EP = 10;
    localparam int CON_LM = 9;
    localparam int CON_CE = 8;
    localparam int CON_LI = 7;
    localparam int CON_EI = 6;
    localparam int CON_LA = 5;
    localparam int CON_EA = 4;
    localparam int CON_SU = 3;
    localparam int CON_EU = 2;
    localparam int CON_LB = 1;
    localparam int CON_LO = 0;
endpackage

// File: rtl/sap1_controller_ring_counter.sv
// ring_counter: one-hot rotate-left T-state generator; clr loads bit 0, en gates rotation.
module ring_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= N'(1);
        else if (en)
            q <= {q[N-2:0], q[N-1]};
    end
endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 T1..T6 sequencer and opcode decoder producing the 12-bit control word.
module sap1_controller
    import sap1_controller_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [OP_W-1:0]     instr_op,
    output logic [T_STATES-1:0] t_state,
    output logic [CON_W-1:0]    con,
    output logic                halted
);
    logic hlt_now;
    // Freeze the ring on the halting edge itself so it stays parked at T4.
    assign hlt_now = t_state[3] && instr_op == OP_HLT;
    ring_counter #(.N(T_STATES)) u_ring (
        .clk (clk),
        .clr (clr),
        .en  (!(halted || hlt_now)),
        .q   (t_state)
    );
    always_ff @(posedge clk) begin
        if (clr)
            halted <= 1'b0;
        else if (hlt_now)
            halted <= 1'b1;
    end
    always_comb begin
        con = '0;
        if (!halted) begin
            if (t_state[0]) begin
                con[CON_EP] = 1'b1;
                con[CON_LM] = 1'b1;
            end
            if (t_state[1])
                con[CON_CP] = 1'b1;
            if (t_state[2]) begin
                con[CON_CE] = 1'b1;
                con[CON_LI] = 1'b1;
            end
            if (t_state[3]) begin
                case (instr_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        con[CON_EI] = 1'b1;
                        con[CON_LM] = 1'b1;
                    end
                    OP_OUT: begin
                        con[CON_EA] = 1'b1;
                        con[CON_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_state[4]) begin
                case (instr_op)
                    OP_LDA: begin
                        con[CON_CE] = 1'b1;
                        con[CON_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        con[CON_CE] = 1'b1;
                        con[CON_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_state[5] && (instr_op == OP_ADD || instr_op == OP_SUB)) begin
                con[CON_EU] = 1'b1;
                con[CON_LA] = 1'b1;
                con[CON_SU] = instr_op == OP_SUB;
            end
        end
    end
endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed and random stimulus checked against a step-count reference model.
module tb_sap1_controller;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  instr_op = 4'h0;
    logic [5:0]  t_state;
    logic [11:0] con;
    logic        halted;
    int n_pass = 0;
    int n_total = 0;
    int m_step = 0;
    bit m_halt = 1'b0;

    sap1_controller dut (
        .clk      (clk),
        .clr      (clr),
        .instr_op (instr_op),
        .t_state  (t_state),
        .con      (con),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] exp_con(input int s, input logic [3:0] op, input bit h);
        if (h) return 12'h000;
        case (s)
            0: return 12'h600;
            1: return 12'h800;
            2: return 12'h180;
            3: return (op <= 4'h2) ? 12'h240 : (op == 4'hE) ? 12'h011 : 12'h000;
            4: return (op == 4'h0) ? 12'h120 : (op == 4'h1 || op == 4'h2) ? 12'h102 : 12'h000;
            5: return (op == 4'h1) ? 12'h024 : (op == 4'h2) ? 12'h02C : 12'h000;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic step(input logic c, input logic [3:0] op);
        @(negedge clk);
        clr = c;
        instr_op = op;
        #1;
        check("t_state", 32'(t_state), 32'(6'b1 << m_step));
        check("halted", 32'(halted), 32'(m_halt));
        check("con", 32'(con), 32'(exp_con(m_step, op, m_halt)));
        check("onehot", 32'($onehot(t_state)), 32'd1);
        check("bus", 32'($countones(con & 12'h554) <= 1), 32'd1);
        @(posedge clk);
        if (c) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 3 && op == 4'hF)
                m_halt = 1'b1;
            else
                m_step = (m_step + 1) % 6;
        end
    endtask

    initial begin
        logic [3:0] ops [6];
        ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h7};
        @(posedge clk);
        #1;
        step(1'b1, 4'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'h0);
        step(1'b1, 4'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'h2);
        for (int i = 0; i < 6; i++) step(1'b0, 4'h1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'hE);
        for (int i = 0; i < 16; i++) step(1'b0, 4'hF);
        check("halt_hold", 32'(t_state), 32'h08);
        step(1'b1, 4'hF);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h1);
        step(1'b1, 4'h1);
        step(1'b0, 4'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'(i * 5));
        step(1'b1, 4'hF);
        for (int i = 0; i < 12; i++) step(1'b0, 4'h7);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 39) == 0,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)]);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
